// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample packer.
//   BYTES_PER_SAMPLE : bytes per 3-axis sample (X LSB, X MSB, Y LSB, Y MSB, Z LSB, Z MSB)
//   state_e          : byte-collection state machine states
//   sample_t         : packed 48-bit {x, y, z} sample
//   sext12           : sign-extends a 12-bit value held in a 16-bit word
package accel_pkg;

   localparam int unsigned BYTES_PER_SAMPLE = 6;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StPush
   } state_e;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } sample_t;

   function automatic logic [15:0] sext12(input logic [15:0] v);
      return {{4{v[11]}}, v[11:0]};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of 48-bit accelerometer samples.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored here and the parent decides what that means.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (pointers/count only)
//   push, wdata      : write request and sample
//   pop              : read request (advances head at the clock edge)
//   rdata            : head sample, zero while empty
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
module sample_fifo
   import accel_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  sample_t     wdata,
   input  logic        pop,
   output sample_t     rdata,
   output logic        full,
   output logic        empty,
   output logic [4:0]  count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Storage is intentionally not reset.
   sample_t           mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [4:0]        count_q;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count_q == 5'(DEPTH));
   assign empty = (count_q == 5'd0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   assign rd_en = pop & ~empty;
   // When full, the slot being written is the head being popped this cycle.
   assign wr_en = push & (~full | rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/accel_sample_packer.sv
// Packs bytes received from an SPI master into 3-axis accelerometer samples
// and buffers them in a small FIFO.
// Optional feature: define ACCEL_SIGN_EXT_EN to sign-extend each axis from
// bit 11 (12-bit sensor data) when the sample is written into the FIFO.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   Load, MISO_Data[7:0]   : received-byte level and data; rising Load is the byte strobe
//   CS                     : chip select, active low; rising edge ends a transaction
//   ovf_clr                : clears the sticky overflow flag
//   sample_ready           : consumer accepts the head sample
//   sample_valid           : FIFO not empty
//   sample_x/y/z           : head sample axes
//   fifo_count             : FIFO occupancy
//   overflow               : sticky, a completed sample was dropped
//   abort_count            : partial samples discarded, saturating at 255
module accel_sample_packer #(
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter int unsigned BYTES_PER_SAMPLE = accel_pkg::BYTES_PER_SAMPLE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Load,
   input  logic [15:0] MISO_Data,
   input  logic        CS,
   input  logic        ovf_clr,
   input  logic        sample_ready,
   output logic        sample_valid,
   output logic [15:0] sample_x,
   output logic [15:0] sample_y,
   output logic [15:0] sample_z,
   output logic [4:0]  fifo_count,
   output logic        overflow,
   output logic [7:0]  abort_count
);

   import accel_pkg::*;

   localparam logic [2:0] LastSlot = 3'(BYTES_PER_SAMPLE - 1);

   state_e      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic        load_q;
   logic        cs_q;
   logic [7:0]  bytes_q [BYTES_PER_SAMPLE];
   logic        overflow_q;
   logic [7:0]  abort_q;

   logic        strobe;
   logic        cs_rise;
   logic        byte_we;
   logic        push;
   logic        abort;
   logic        pop;
   logic        full;
   logic        empty;
   sample_t     wr_sample;
   sample_t     head;
   logic        unused_miso;

   assign unused_miso = ^MISO_Data[15:8];

   assign strobe  = Load & ~load_q;
   assign cs_rise = CS & ~cs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         load_q  <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         load_q  <= Load;
         cs_q    <= CS;
      end
   end

   // In IDLE the pointer is always 0, so every capture writes slot ptr_q.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      byte_we = 1'b0;
      push    = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (strobe) begin
               byte_we = 1'b1;
               ptr_d   = 3'd1;
               state_d = StCollect;
            end
         end
         StCollect: begin
            // An aborting CS edge wins over a coincident strobe.
            if (cs_rise) begin
               abort   = 1'b1;
               ptr_d   = '0;
               state_d = StIdle;
            end else if (strobe) begin
               byte_we = 1'b1;
               ptr_d   = ptr_q + 3'd1;
               if (ptr_q == LastSlot) begin
                  state_d = StPush;
               end
            end
         end
         StPush: begin
            push    = 1'b1;
            ptr_d   = '0;
            state_d = StIdle;
         end
         default: begin
            ptr_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (byte_we) begin
         bytes_q[ptr_q] <= MISO_Data[7:0];
      end
   end

   always_comb begin
      wr_sample.x = {bytes_q[1], bytes_q[0]};
      wr_sample.y = {bytes_q[3], bytes_q[2]};
      wr_sample.z = {bytes_q[5], bytes_q[4]};
`ifdef ACCEL_SIGN_EXT_EN
      wr_sample.x = sext12(wr_sample.x);
      wr_sample.y = sext12(wr_sample.y);
      wr_sample.z = sext12(wr_sample.z);
`endif
   end

   assign pop = ~empty & sample_ready;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_sample),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // A new drop outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
         abort_q    <= '0;
      end else begin
         if (push && full && !pop) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
         if (abort && (abort_q != 8'hFF)) begin
            abort_q <= abort_q + 8'd1;
         end
      end
   end

   assign sample_valid = ~empty;
   assign sample_x     = head.x;
   assign sample_y     = head.y;
   assign sample_z     = head.z;
   assign overflow     = overflow_q;
   assign abort_count  = abort_q;

endmodule

// File: tb/tb_accel_sample_packer.sv
// Directed self-checking bench for accel_sample_packer (FIFO_DEPTH = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_accel_sample_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        Load;
   logic [15:0] MISO_Data;
   logic        CS;
   logic        ovf_clr;
   logic        sample_ready;
   logic        sample_valid;
   logic [15:0] sample_x;
   logic [15:0] sample_y;
   logic [15:0] sample_z;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic [7:0]  abort_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   accel_sample_packer #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .Load         (Load),
      .MISO_Data    (MISO_Data),
      .CS           (CS),
      .ovf_clr      (ovf_clr),
      .sample_ready (sample_ready),
      .sample_valid (sample_valid),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .sample_z     (sample_z),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .abort_count  (abort_count)
   );

   task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte k of a sample {x,y,z} in wire order X LSB, X MSB, Y LSB, Y MSB, Z LSB, Z MSB.
   function automatic logic [7:0] byte_of(input logic [47:0] s, input int k);
      case (k)
         0:       return s[39:32];
         1:       return s[47:40];
         2:       return s[23:16];
         3:       return s[31:24];
         4:       return s[7:0];
         default: return s[15:8];
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      MISO_Data = {8'h00, b};
      Load      = 1'b1;
      repeat (hold) @(negedge clk);
      Load = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_sample(input logic [47:0] s, input int hold);
      for (int k = 0; k < 6; k++) begin
         send_byte(byte_of(s, k), hold);
      end
   endtask

   task automatic cs_pulse();
      @(negedge clk);
      CS = 1'b1;
      @(negedge clk);
      CS = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [47:0] exp);
      check_eq({tag, "_valid"}, 48'(sample_valid), 48'd1);
      check_eq({tag, "_xyz"}, {sample_x, sample_y, sample_z}, exp);
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
   endtask

   logic [7:0]  s1_bytes [6];
   logic [47:0] samp [5];
   logic [47:0] sx_exp;

   initial begin
      rst          = 1'b1;
      Load         = 1'b0;
      CS           = 1'b0;
      MISO_Data    = '0;
      ovf_clr      = 1'b0;
      sample_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_eq("rst_valid", 48'(sample_valid), 48'd0);
      check_eq("rst_count", 48'(fifo_count), 48'd0);
      check_eq("rst_ovf", 48'(overflow), 48'd0);
      check_eq("rst_abort", 48'(abort_count), 48'd0);
      check_eq("rst_xyz", {sample_x, sample_y, sample_z}, 48'd0);

      // Long Load levels produce one strobe each; latency from the 6th strobe
      s1_bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
      for (int k = 0; k < 5; k++) begin
         send_byte(s1_bytes[k], 50);
      end
      @(negedge clk);
      MISO_Data = {8'h00, s1_bytes[5]};
      Load      = 1'b1;
      @(negedge clk);
      check_eq("lat_push_cycle", 48'(sample_valid), 48'd0);
      @(negedge clk);
      check_eq("lat_valid", 48'(sample_valid), 48'd1);
      repeat (48) @(negedge clk);
      Load = 1'b0;
      @(negedge clk);
      check_eq("s1_count", 48'(fifo_count), 48'd1);
      pop_check("s1", 48'h1234_5678_9ABC);
      check_eq("s1_empty", 48'(sample_valid), 48'd0);

      // Abort a partial sample with a CS rising edge
      do_reset();
      send_byte(8'hAA, 3);
      send_byte(8'hBB, 3);
      send_byte(8'hCC, 3);
      cs_pulse();
      @(negedge clk);
      check_eq("ab_count", 48'(abort_count), 48'd1);
      check_eq("ab_nosample", 48'(sample_valid), 48'd0);
      for (int k = 0; k < 6; k++) begin
         send_byte(8'(k + 1), 3);
      end
      check_eq("ab_fifo", 48'(fifo_count), 48'd1);
      pop_check("ab", 48'h0201_0403_0605);

      // Overflow: five samples into a depth-4 FIFO with no consumer
      do_reset();
      samp = '{48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999,
               48'hAAAA_BBBB_CCCC, 48'hDDDD_EEEE_FFFF};
      for (int i = 0; i < 5; i++) begin
         send_sample(samp[i], 2);
      end
      check_eq("ov_count", 48'(fifo_count), 48'd4);
      check_eq("ov_flag", 48'(overflow), 48'd1);
      for (int i = 0; i < 4; i++) begin
         pop_check($sformatf("ov_pop%0d", i), samp[i]);
      end
      check_eq("ov_drained", 48'(sample_valid), 48'd0);
      check_eq("ov_sticky", 48'(overflow), 48'd1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check_eq("ov_clr", 48'(overflow), 48'd0);

      // Push and pop together while full: nothing dropped
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_sample(samp[i], 2);
      end
      check_eq("pp_full", 48'(fifo_count), 48'd4);
      for (int k = 0; k < 5; k++) begin
         send_byte(byte_of(samp[4], k), 2);
      end
      @(negedge clk);
      MISO_Data = {8'h00, byte_of(samp[4], 5)};
      Load      = 1'b1;
      @(negedge clk);
      sample_ready = 1'b1;            // this cycle is the PUSH cycle
      @(negedge clk);
      sample_ready = 1'b0;
      Load         = 1'b0;
      check_eq("pp_count", 48'(fifo_count), 48'd4);
      check_eq("pp_ovf", 48'(overflow), 48'd0);
      for (int i = 1; i < 5; i++) begin
         pop_check($sformatf("pp_pop%0d", i), samp[i]);
      end

      // Reset mid-sample discards the partial bytes without counting an abort
      do_reset();
      for (int k = 0; k < 4; k++) begin
         send_byte(8'h11 * 8'(k + 1), 2);
      end
      do_reset();
      send_sample(48'hCAFE_BEEF_F00D, 2);
      check_eq("mr_count", 48'(fifo_count), 48'd1);
      check_eq("mr_abort", 48'(abort_count), 48'd0);
      check_eq("mr_ovf", 48'(overflow), 48'd0);
      pop_check("mr", 48'hCAFE_BEEF_F00D);

      // Sign extension option; CS edge during PUSH must not abort it
      do_reset();
      s1_bytes = '{8'h00, 8'h08, 8'hFF, 8'h0F, 8'h34, 8'h02};
      for (int k = 0; k < 5; k++) begin
         send_byte(s1_bytes[k], 2);
      end
      @(negedge clk);
      MISO_Data = {8'h00, s1_bytes[5]};
      Load      = 1'b1;
      @(negedge clk);
      CS = 1'b1;                      // edge seen while in PUSH
      @(negedge clk);
      CS   = 1'b0;
      Load = 1'b0;
      @(negedge clk);
      check_eq("sx_abort", 48'(abort_count), 48'd0);
      check_eq("sx_count", 48'(fifo_count), 48'd1);
`ifdef ACCEL_SIGN_EXT_EN
      sx_exp = 48'hF800_FFFF_0234;
`else
      sx_exp = 48'h0800_0FFF_0234;
`endif
      pop_check("sx", sx_exp);

      // abort_count saturates at 255
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h55, 1);
         cs_pulse();
      end
      @(negedge clk);
      check_eq("sat_abort", 48'(abort_count), 48'd255);
      check_eq("sat_empty", 48'(sample_valid), 48'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
